// File: rtl/cpu_addr_path.sv
// CPU register/address datapath: PC, IRU/IRL, SP and stack depth tracking,
// plus the single RAM address/write-data mux driven by the control FSM strobes.
module cpu_addr_path #(
    parameter int                ADDR_W   = 8,
    parameter int                DATA_W   = 8,
    parameter logic [ADDR_W-1:0] SP_INIT  = ADDR_W'(8'h00),
    parameter logic [ADDR_W-1:0] SP_LIMIT = ADDR_W'(8'hE0)
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              FETCH,
    input  logic              INC_PC,
    input  logic              LOAD_PC,
    input  logic              LOAD_IRU,
    input  logic              LOAD_IRL,
    input  logic              LOAD_SP,
    input  logic              SP_INC,
    input  logic              SP_DEC,
    input  logic              DO_PUSH,
    input  logic              DO_POP,
    input  logic              DO_JSR,
    input  logic              DO_RTS,
    input  logic              SP_ADDR,
    input  logic              STORE_MEM,
    input  logic [DATA_W-1:0] ac,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [7:0]        opcode,
    output logic [ADDR_W-1:0] irl,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] sp,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic [ADDR_W:0]   depth,
    output logic              stk_ovf,
    output logic              stk_unf,
    output logic              stk_err
);

    localparam logic [ADDR_W:0] DEPTH_MAX = {1'b1, {ADDR_W{1'b0}}};

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] irl_q, irl_d;
    logic [ADDR_W-1:0] sp_q, sp_d;
    logic [7:0]        iru_q, iru_d;
    logic [ADDR_W:0]   depth_q, depth_d;
    logic              rd_hold_q, rd_hold_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] sp_m1, sp_p1;
    logic              unused_push;

    // Push is fully described by SP_ADDR/SP_DEC/STORE_MEM; the qualifier is informational.
    assign unused_push = DO_PUSH;

    assign sp_m1 = sp_q - ADDR_W'(1);
    assign sp_p1 = sp_q + ADDR_W'(1);

    // rd_hold keeps the stack address live through the second read phase of POP/RTS.
    always_comb begin
        if (SP_ADDR || rd_hold_q) begin
            mem_addr = SP_DEC ? sp_m1 : sp_q;
        end else if (FETCH) begin
            mem_addr = pc_q;
        end else begin
            mem_addr = irl_q;
        end
    end

    assign mem_wdata = DO_JSR ? DATA_W'(pc_q) : ac;
    assign mem_we    = STORE_MEM;

    always_comb begin
        pc_d      = pc_q;
        iru_d     = iru_q;
        irl_d     = irl_q;
        sp_d      = sp_q;
        depth_d   = depth_q;
        ovf_d     = ovf_q;
        unf_d     = unf_q;
        err_d     = err_q;
        rd_hold_d = (DO_POP || DO_RTS) && !rd_hold_q;

        if (LOAD_PC) begin
            pc_d = rd_hold_q ? ADDR_W'(mem_rdata) : irl_q;
        end else if (INC_PC) begin
            pc_d = pc_q + ADDR_W'(1);
        end

        if (LOAD_IRU) iru_d = 8'(mem_rdata);
        if (LOAD_IRL) irl_d = ADDR_W'(mem_rdata);

        // SP still wraps on over/underflow; only the sticky flag records the fault.
        if (LOAD_SP) begin
            sp_d    = irl_q;
            depth_d = '0;
            ovf_d   = 1'b0;
            unf_d   = 1'b0;
            err_d   = 1'b0;
        end else if (SP_INC && SP_DEC) begin
            err_d = 1'b1;
        end else if (SP_DEC) begin
            sp_d = sp_m1;
            if (sp_q == SP_LIMIT) ovf_d = 1'b1;
            if (depth_q != DEPTH_MAX) depth_d = depth_q + (ADDR_W+1)'(1);
        end else if (SP_INC) begin
            sp_d = sp_p1;
            if (sp_q == SP_INIT) unf_d = 1'b1;
            if (depth_q != '0) depth_d = depth_q - (ADDR_W+1)'(1);
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            pc_q      <= '0;
            iru_q     <= '0;
            irl_q     <= '0;
            sp_q      <= SP_INIT;
            depth_q   <= '0;
            rd_hold_q <= 1'b0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            iru_q     <= iru_d;
            irl_q     <= irl_d;
            sp_q      <= sp_d;
            depth_q   <= depth_d;
            rd_hold_q <= rd_hold_d;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
            err_q     <= err_d;
        end
    end

    assign opcode  = iru_q;
    assign irl     = irl_q;
    assign pc      = pc_q;
    assign sp      = sp_q;
    assign depth   = depth_q;
    assign stk_ovf = ovf_q;
    assign stk_unf = unf_q;
    assign stk_err = err_q;

endmodule

// File: tb/tb_cpu_addr_path.sv
// Bench for cpu_addr_path: directed stack/JSR/RTS/flag scenarios plus a random
// strobe sequence checked against an arithmetic model of the register file.
module tb_cpu_addr_path;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       FETCH, INC_PC, LOAD_PC, LOAD_IRU, LOAD_IRL, LOAD_SP;
    logic       SP_INC, SP_DEC, DO_PUSH, DO_POP, DO_JSR, DO_RTS, SP_ADDR, STORE_MEM;
    logic [7:0] ac;
    logic [7:0] mem_rdata;
    logic [7:0] opcode, irl, pc, sp, mem_addr, mem_wdata;
    logic       mem_we;
    logic [8:0] depth;
    logic       stk_ovf, stk_unf, stk_err;

    logic [7:0] ram [256];
    int errors = 0;
    int checks = 0;

    localparam logic [13:0] M_FETCH   = 14'h0001;
    localparam logic [13:0] M_INC_PC  = 14'h0002;
    localparam logic [13:0] M_LOAD_PC = 14'h0004;
    localparam logic [13:0] M_IRU     = 14'h0008;
    localparam logic [13:0] M_IRL     = 14'h0010;
    localparam logic [13:0] M_LOAD_SP = 14'h0020;
    localparam logic [13:0] M_SP_INC  = 14'h0040;
    localparam logic [13:0] M_SP_DEC  = 14'h0080;
    localparam logic [13:0] M_PUSH    = 14'h0100;
    localparam logic [13:0] M_POP     = 14'h0200;
    localparam logic [13:0] M_JSR     = 14'h0400;
    localparam logic [13:0] M_RTS     = 14'h0800;
    localparam logic [13:0] M_SP_ADDR = 14'h1000;
    localparam logic [13:0] M_STORE   = 14'h2000;

    cpu_addr_path dut (
        .CLK(CLK), .RESET(RESET), .FETCH(FETCH), .INC_PC(INC_PC), .LOAD_PC(LOAD_PC),
        .LOAD_IRU(LOAD_IRU), .LOAD_IRL(LOAD_IRL), .LOAD_SP(LOAD_SP), .SP_INC(SP_INC),
        .SP_DEC(SP_DEC), .DO_PUSH(DO_PUSH), .DO_POP(DO_POP), .DO_JSR(DO_JSR),
        .DO_RTS(DO_RTS), .SP_ADDR(SP_ADDR), .STORE_MEM(STORE_MEM), .ac(ac),
        .mem_rdata(mem_rdata), .opcode(opcode), .irl(irl), .pc(pc), .sp(sp),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .depth(depth),
        .stk_ovf(stk_ovf), .stk_unf(stk_unf), .stk_err(stk_err)
    );

    assign mem_rdata = ram[mem_addr];

    always #5 CLK = ~CLK;

    task automatic apply(input logic [13:0] s, input logic [7:0] a);
        FETCH = s[0];  INC_PC = s[1];  LOAD_PC = s[2];  LOAD_IRU = s[3];
        LOAD_IRL = s[4]; LOAD_SP = s[5]; SP_INC = s[6]; SP_DEC = s[7];
        DO_PUSH = s[8]; DO_POP = s[9]; DO_JSR = s[10]; DO_RTS = s[11];
        SP_ADDR = s[12]; STORE_MEM = s[13]; ac = a;
    endtask

    // Strobes change on the falling edge, as the FSM drives them.
    task automatic drive(input logic [13:0] s, input logic [7:0] a);
        @(negedge CLK);
        RESET = 1'b0;
        apply(s, a);
    endtask

    // RAM write lands just after the rising edge so the DUT sees pre-edge read data.
    task automatic clk_step();
        logic       wr;
        logic [7:0] wa, wd;
        wr = mem_we; wa = mem_addr; wd = mem_wdata;
        @(posedge CLK);
        #1;
        if (wr) ram[wa] = wd;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RESET = 1'b1;
        apply(14'h0, 8'h00);
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (pc !== 8'h00) begin errors++; $display("FAIL reset_pc got=%h exp=00", pc); end
        checks++; if (opcode !== 8'h00) begin errors++; $display("FAIL reset_opcode got=%h exp=00", opcode); end
        checks++; if (irl !== 8'h00) begin errors++; $display("FAIL reset_irl got=%h exp=00", irl); end
        checks++; if (sp !== 8'h00) begin errors++; $display("FAIL reset_sp got=%h exp=00", sp); end
        checks++; if (depth !== 9'h000) begin errors++; $display("FAIL reset_depth got=%h exp=000", depth); end
        checks++; if ({stk_ovf, stk_unf, stk_err} !== 3'b000) begin errors++; $display("FAIL reset_flags got=%b exp=000", {stk_ovf, stk_unf, stk_err}); end
        STORE_MEM = 1'b1; #1;
        checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL reset_we_hi got=%b exp=1", mem_we); end
        STORE_MEM = 1'b0; #1;
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_we_lo got=%b exp=0", mem_we); end
    endtask

    task automatic test_fetch();
        ram[0] = 8'h16;
        drive(M_FETCH | M_INC_PC | M_IRU, 8'h00); #2;
        checks++; if (mem_addr !== 8'h00) begin errors++; $display("FAIL fetch_addr got=%h exp=00", mem_addr); end
        clk_step();
        checks++; if (opcode !== 8'h16) begin errors++; $display("FAIL fetch_opcode got=%h exp=16", opcode); end
        checks++; if (pc !== 8'h01) begin errors++; $display("FAIL fetch_pc got=%h exp=01", pc); end
    endtask

    task automatic test_push();
        ram[1] = 8'h80;
        drive(M_FETCH | M_INC_PC | M_IRL, 8'h00); clk_step();
        checks++; if (irl !== 8'h80) begin errors++; $display("FAIL push_irl got=%h exp=80", irl); end
        drive(M_LOAD_SP, 8'h00); clk_step();
        checks++; if (sp !== 8'h80) begin errors++; $display("FAIL push_loadsp got=%h exp=80", sp); end
        drive(M_SP_ADDR | M_SP_DEC | M_PUSH | M_STORE, 8'h5A); #2;
        checks++; if (mem_addr !== 8'h7F) begin errors++; $display("FAIL push_addr got=%h exp=7f", mem_addr); end
        checks++; if (mem_wdata !== 8'h5A) begin errors++; $display("FAIL push_wdata got=%h exp=5a", mem_wdata); end
        checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL push_we got=%b exp=1", mem_we); end
        clk_step();
        checks++; if (sp !== 8'h7F) begin errors++; $display("FAIL push_sp got=%h exp=7f", sp); end
        checks++; if (depth !== 9'd1) begin errors++; $display("FAIL push_depth got=%0d exp=1", depth); end
        checks++; if (ram[8'h7F] !== 8'h5A) begin errors++; $display("FAIL push_mem got=%h exp=5a", ram[8'h7F]); end
    endtask

    task automatic test_pop();
        drive(M_SP_ADDR | M_POP, 8'h00); #2;
        checks++; if (mem_addr !== 8'h7F) begin errors++; $display("FAIL pop1_addr got=%h exp=7f", mem_addr); end
        checks++; if (mem_rdata !== 8'h5A) begin errors++; $display("FAIL pop1_data got=%h exp=5a", mem_rdata); end
        clk_step();
        drive(M_SP_INC, 8'h00); #2;
        checks++; if (mem_addr !== 8'h7F) begin errors++; $display("FAIL pop2_addr got=%h exp=7f", mem_addr); end
        clk_step();
        checks++; if (sp !== 8'h80) begin errors++; $display("FAIL pop_sp got=%h exp=80", sp); end
        checks++; if (depth !== 9'd0) begin errors++; $display("FAIL pop_depth got=%0d exp=0", depth); end
    endtask

    task automatic test_jsr_rts();
        ram[2] = 8'h11; ram[8'h11] = 8'h40;
        drive(M_FETCH | M_IRL, 8'h00); clk_step();
        drive(M_LOAD_PC, 8'h00); clk_step();
        checks++; if (pc !== 8'h11) begin errors++; $display("FAIL jump_pc got=%h exp=11", pc); end
        drive(M_FETCH | M_INC_PC | M_IRL, 8'h00); clk_step();
        checks++; if ({pc, irl} !== 16'h1240) begin errors++; $display("FAIL jsr_setup got=%h exp=1240", {pc, irl}); end
        drive(M_SP_ADDR | M_SP_DEC | M_JSR | M_STORE | M_LOAD_PC, 8'hEE); #2;
        checks++; if (mem_addr !== 8'h7F) begin errors++; $display("FAIL jsr_addr got=%h exp=7f", mem_addr); end
        checks++; if (mem_wdata !== 8'h12) begin errors++; $display("FAIL jsr_wdata got=%h exp=12", mem_wdata); end
        clk_step();
        checks++; if (pc !== 8'h40) begin errors++; $display("FAIL jsr_pc got=%h exp=40", pc); end
        checks++; if (sp !== 8'h7F) begin errors++; $display("FAIL jsr_sp got=%h exp=7f", sp); end
        checks++; if (ram[8'h7F] !== 8'h12) begin errors++; $display("FAIL jsr_mem got=%h exp=12", ram[8'h7F]); end
        drive(M_SP_ADDR | M_RTS, 8'h00); #2;
        checks++; if (mem_addr !== 8'h7F) begin errors++; $display("FAIL rts1_addr got=%h exp=7f", mem_addr); end
        clk_step();
        drive(M_LOAD_PC | M_SP_INC, 8'h00); #2;
        checks++; if (mem_addr !== 8'h7F) begin errors++; $display("FAIL rts2_addr got=%h exp=7f", mem_addr); end
        clk_step();
        checks++; if (pc !== 8'h12) begin errors++; $display("FAIL rts_pc got=%h exp=12", pc); end
        checks++; if (sp !== 8'h80) begin errors++; $display("FAIL rts_sp got=%h exp=80", sp); end
    endtask

    task automatic test_store();
        drive(M_STORE, 8'hA5); #2;
        checks++; if ({mem_addr, mem_wdata, mem_we} !== {8'h40, 8'hA5, 1'b1}) begin errors++; $display("FAIL store_bus got=%h/%h/%b exp=40/a5/1", mem_addr, mem_wdata, mem_we); end
        clk_step();
        checks++; if (ram[8'h40] !== 8'hA5) begin errors++; $display("FAIL store_mem got=%h exp=a5", ram[8'h40]); end
    endtask

    task automatic test_flags();
        do_reset();
        drive(M_SP_INC, 8'h00); clk_step();
        checks++; if ({sp, stk_unf} !== {8'h01, 1'b1}) begin errors++; $display("FAIL unf got=%h/%b exp=01/1", sp, stk_unf); end
        checks++; if (depth !== 9'd0) begin errors++; $display("FAIL unf_depth got=%0d exp=0", depth); end
        ram[0] = 8'hE0;
        drive(M_FETCH | M_IRL, 8'h00); clk_step();
        drive(M_LOAD_SP, 8'h00); clk_step();
        checks++; if ({sp, stk_unf} !== {8'hE0, 1'b0}) begin errors++; $display("FAIL loadsp_clr got=%h/%b exp=e0/0", sp, stk_unf); end
        drive(M_SP_DEC, 8'h00); clk_step();
        checks++; if ({sp, stk_ovf} !== {8'hDF, 1'b1}) begin errors++; $display("FAIL ovf got=%h/%b exp=df/1", sp, stk_ovf); end
        drive(M_SP_INC | M_SP_DEC, 8'h00); clk_step();
        checks++; if ({sp, stk_err, depth} !== {8'hDF, 1'b1, 9'd1}) begin errors++; $display("FAIL err got=%h/%b/%0d exp=df/1/1", sp, stk_err, depth); end
    endtask

    task automatic test_depth_sat();
        do_reset();
        for (int i = 0; i < 260; i++) begin
            drive(M_SP_DEC, 8'h00); clk_step();
        end
        checks++; if ({depth, sp, stk_ovf} !== {9'h100, 8'hFC, 1'b1}) begin errors++; $display("FAIL depth_sat got=%h/%h/%b exp=100/fc/1", depth, sp, stk_ovf); end
        drive(M_SP_INC, 8'h00); clk_step();
        checks++; if (depth !== 9'd255) begin errors++; $display("FAIL depth_after_sat got=%0d exp=255", depth); end
    endtask

    task automatic test_reset_mid_pop();
        do_reset();
        drive(M_SP_ADDR | M_SP_DEC | M_PUSH | M_STORE, 8'h33); clk_step();
        drive(M_SP_ADDR | M_POP, 8'h00); clk_step();
        drive(M_SP_INC, 8'h00); #2;
        RESET = 1'b1; #1;
        checks++; if ({sp, depth} !== {8'h00, 9'd0}) begin errors++; $display("FAIL midrst_sp got=%h/%0d exp=00/0", sp, depth); end
        @(posedge CLK); #1;
        ram[0] = 8'hE0;
        drive(M_FETCH | M_LOAD_PC, 8'h00); #2;
        checks++; if (mem_addr !== 8'h00) begin errors++; $display("FAIL midrst_addr got=%h exp=00", mem_addr); end
        clk_step();
        checks++; if (pc !== 8'h00) begin errors++; $display("FAIL midrst_hold got=%h exp=00", pc); end
    endtask

    task automatic test_random();
        logic [7:0] ref_mem [256];
        int m_pc, m_sp, m_iru, m_irl, m_depth, a, rd, wd, n_pc;
        bit m_ovf, m_unf, m_err, m_hold;
        logic [13:0] s;
        logic [7:0] acv;
        do_reset();
        for (int i = 0; i < 256; i++) begin
            ram[i] = 8'($urandom);
            ref_mem[i] = ram[i];
        end
        m_pc = 0; m_sp = 0; m_iru = 0; m_irl = 0; m_depth = 0;
        m_ovf = 0; m_unf = 0; m_err = 0; m_hold = 0;
        for (int c = 0; c < 400; c++) begin
            for (int b = 0; b < 14; b++) s[b] = ($urandom_range(0, 3) == 0);
            acv = 8'($urandom);
            drive(s, acv); #2;
            if (s[12] || m_hold) a = s[7] ? (m_sp + 255) % 256 : m_sp;
            else if (s[0]) a = m_pc;
            else a = m_irl;
            rd = ref_mem[a];
            wd = s[10] ? m_pc : acv;
            checks++; if (mem_addr !== 8'(a)) begin errors++; $display("FAIL rnd_addr c=%0d got=%h exp=%h", c, mem_addr, 8'(a)); end
            checks++; if (mem_we !== s[13]) begin errors++; $display("FAIL rnd_we c=%0d got=%b exp=%b", c, mem_we, s[13]); end
            checks++; if (mem_wdata !== 8'(wd)) begin errors++; $display("FAIL rnd_wdata c=%0d got=%h exp=%h", c, mem_wdata, 8'(wd)); end
            if (s[13]) ref_mem[a] = 8'(wd);
            if (s[2]) n_pc = m_hold ? rd : m_irl;
            else if (s[1]) n_pc = (m_pc + 1) % 256;
            else n_pc = m_pc;
            if (s[3]) m_iru = rd;
            if (s[5]) begin
                m_sp = m_irl; m_depth = 0; m_ovf = 0; m_unf = 0; m_err = 0;
            end else if (s[6] && s[7]) begin
                m_err = 1;
            end else if (s[7]) begin
                if (m_sp == 224) m_ovf = 1;
                m_sp = (m_sp + 255) % 256;
                m_depth = (m_depth < 256) ? m_depth + 1 : 256;
            end else if (s[6]) begin
                if (m_sp == 0) m_unf = 1;
                m_sp = (m_sp + 1) % 256;
                m_depth = (m_depth > 0) ? m_depth - 1 : 0;
            end
            if (s[4]) m_irl = rd;
            m_pc = n_pc;
            m_hold = (s[9] || s[11]) && !m_hold;
            clk_step();
            checks++; if (pc !== 8'(m_pc)) begin errors++; $display("FAIL rnd_pc c=%0d got=%h exp=%h", c, pc, 8'(m_pc)); end
            checks++; if (sp !== 8'(m_sp)) begin errors++; $display("FAIL rnd_sp c=%0d got=%h exp=%h", c, sp, 8'(m_sp)); end
            checks++; if ({opcode, irl} !== {8'(m_iru), 8'(m_irl)}) begin errors++; $display("FAIL rnd_ir c=%0d got=%h exp=%h", c, {opcode, irl}, {8'(m_iru), 8'(m_irl)}); end
            checks++; if (depth !== 9'(m_depth)) begin errors++; $display("FAIL rnd_depth c=%0d got=%0d exp=%0d", c, depth, m_depth); end
            checks++; if ({stk_ovf, stk_unf, stk_err} !== {m_ovf, m_unf, m_err}) begin errors++; $display("FAIL rnd_flags c=%0d got=%b exp=%b", c, {stk_ovf, stk_unf, stk_err}, {m_ovf, m_unf, m_err}); end
        end
    endtask

    initial begin
        RESET = 1'b1;
        apply(14'h0, 8'h00);
        for (int i = 0; i < 256; i++) ram[i] = 8'h00;
        test_reset();
        test_fetch();
        test_push();
        test_pop();
        test_jsr_rts();
        test_store();
        test_flags();
        test_depth_sat();
        test_reset_mid_pop();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
